// File: rtl/shmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : shmem_responder
// Purpose  : Round-robin shared-memory responder for the GPU core array.
//            One access at a time on a single-port 2**ADDR_W x DATA_W RAM;
//            each access is IDLE(grant) -> ACCESS -> RESP(val_data pulse).
// Options  : SHMEM_PERF_CNT_EN enables the perf_ld/perf_st/perf_wait counters;
//            without it those outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module shmem_responder #(
  parameter int NUM_CORES = 16,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          mem_req_ld,
  input  logic [NUM_CORES-1:0]          mem_req_st,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr_flat,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata_flat,
  output logic [NUM_CORES-1:0]          val_data,
  output logic [DATA_W-1:0]             mem_dat,
  output logic                          req_err,
  output logic                          busy,
  output logic [15:0]                   perf_ld,
  output logic [15:0]                   perf_st,
  output logic [15:0]                   perf_wait
);

  localparam int                 c_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int                 c_DEPTH = 2 ** ADDR_W;
  localparam logic [c_IDX_W:0]   c_NUM   = NUM_CORES[c_IDX_W:0];
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   r_last_core;
  logic                 r_guard;
  logic [c_IDX_W-1:0]   r_grant;
  logic                 r_op_st;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_mem [c_DEPTH];

  logic [ADDR_W-1:0]    w_addr  [NUM_CORES];
  logic [DATA_W-1:0]    w_wdata [NUM_CORES];
  logic [NUM_CORES-1:0] w_pend;
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_grant;
  logic [c_IDX_W:0]     w_sum;
  logic [c_IDX_W-1:0]   w_next;

  generate
    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
      assign w_addr[k]  = addr_flat[k*ADDR_W +: ADDR_W];
      assign w_wdata[k] = wdata_flat[k*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: first pending core at or above rr_ptr, wrapping; the
  // core just served is masked for one cycle because its request is still
  // visible until it has sampled val_data.
  always_comb begin
    w_pend  = mem_req_ld | mem_req_st;
    if (r_guard) w_pend[r_last_core] = 1'b0;
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_sum = {1'b0, r_rr_ptr} + i[c_IDX_W:0];
      if (w_sum >= c_NUM) w_sum = w_sum - c_NUM;
      if (!w_found && w_pend[w_sum[c_IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[c_IDX_W-1:0];
      end
    end
    w_next = (w_grant == c_LAST) ? '0 : w_grant + 1'b1;
  end

  // Access sequencer: grant/latch in IDLE, RAM cycle in ACCESS, pulse in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_last_core <= '0;
      r_guard     <= 1'b0;
      r_grant     <= '0;
      r_op_st     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      val_data    <= '0;
      req_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      val_data <= '0;
      case (r_state)
        S_IDLE: begin
          r_guard <= 1'b0;
          if (w_found) begin
            r_grant  <= w_grant;
            r_op_st  <= mem_req_st[w_grant];
            r_addr   <= w_addr[w_grant];
            r_wdata  <= w_wdata[w_grant];
            r_rr_ptr <= w_next;
            busy     <= 1'b1;
            r_state  <= S_ACCESS;
            if (mem_req_ld[w_grant] && mem_req_st[w_grant]) req_err <= 1'b1;
          end
        end
        S_ACCESS: begin
          val_data[r_grant] <= 1'b1;
          r_state           <= S_RESP;
        end
        S_RESP: begin
          r_guard     <= 1'b1;
          r_last_core <= r_grant;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM write port; a store caught by reset in ACCESS never lands.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_ACCESS && r_op_st) r_mem[r_addr] <= r_wdata;
  end

  // Registered read data, valid in the same cycle as the load's val_data pulse.
  always_ff @(posedge clk) begin
    if (reset)                                   mem_dat <= '0;
    else if (r_state == S_ACCESS && !r_op_st)    mem_dat <= r_mem[r_addr];
  end

`ifdef SHMEM_PERF_CNT_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld   <= '0;
      perf_st   <= '0;
      perf_wait <= '0;
    end else begin
      if (r_state == S_RESP && !r_op_st && perf_ld != 16'hFFFF) perf_ld <= perf_ld + 1'b1;
      if (r_state == S_RESP &&  r_op_st && perf_st != 16'hFFFF) perf_st <= perf_st + 1'b1;
      if ((|(mem_req_ld | mem_req_st)) && !(|val_data) && r_state != S_ACCESS &&
          perf_wait != 16'hFFFF)
        perf_wait <= perf_wait + 1'b1;
    end
  end
`else
  assign perf_ld   = '0;
  assign perf_st   = '0;
  assign perf_wait = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_shmem_responder
// Purpose  : Directed + random bench for shmem_responder against a
//            transaction-level model (arbitration, memory image, counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shmem_responder;

  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    mem_req_ld, mem_req_st;
  logic [N*AW-1:0] addr_flat;
  logic [N*DW-1:0] wdata_flat;
  logic [N-1:0]    val_data;
  logic [DW-1:0]   mem_dat;
  logic            req_err, busy;
  logic [15:0]     perf_ld, perf_st, perf_wait;

  always #5 clk = ~clk;

  shmem_responder #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .mem_req_ld(mem_req_ld), .mem_req_st(mem_req_st),
    .addr_flat(addr_flat), .wdata_flat(wdata_flat),
    .val_data(val_data), .mem_dat(mem_dat), .req_err(req_err), .busy(busy),
    .perf_ld(perf_ld), .perf_st(perf_st), .perf_wait(perf_wait)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Core-side request state
  bit          c_act [N];
  bit          c_ld  [N];
  bit          c_st  [N];
  bit          c_renew [N];
  logic [11:0] c_addr [N];
  logic [7:0]  c_data [N];
  bit          rand_en  = 0;
  int          rand_pct = 0;
  bit          rst_pending = 1;

  // Reference model state
  int          cyc = 0;
  bit          t_valid = 0;
  int          t_core, t_grant, t_done;
  bit          t_st;
  logic [11:0] t_addr;
  logic [7:0]  t_data;
  int          m_rr = 0, m_free = 0, m_gcyc = -1, m_gcore = 0;
  int          err_cyc = -1;
  logic [7:0]  mm [4096];
  bit          mk [4096];
  logic [7:0]  e_dat = '0;
  bit          e_dat_ok = 0;
  int          p_ld = 0, p_st = 0, p_wait = 0;
  int          done_cyc [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic issue(input int k, input bit ld, input bit st,
                       input logic [11:0] a, input logic [7:0] d);
    c_act[k] = 1; c_ld[k] = ld; c_st[k] = st; c_addr[k] = a; c_data[k] = d;
  endtask

  task automatic new_req(input int k);
    bit s;
    s = bit'($urandom_range(1));
    issue(k, !s, s, 12'h300 + 12'($urandom_range(15)), 8'($urandom));
  endtask

  function automatic bit any_act();
    for (int k = 0; k < N; k++) if (c_act[k]) return 1;
    return 0;
  endfunction

  // One clock: check DUT against model, evolve cores, drive, then arbitrate.
  task automatic cycle();
    logic [N-1:0] e_val, pend, reqv;
    bit acc_now;
    int g;
    @(posedge clk); #1; cyc++;
    e_val = '0;
    if (t_valid && cyc == t_done) begin
      e_val[t_core] = 1'b1;
      if (t_st) begin mm[t_addr] = t_data; mk[t_addr] = 1; end
      else begin e_dat = mm[t_addr]; e_dat_ok = mk[t_addr]; end
    end
    chk("val_data", 32'(val_data), 32'(e_val));
    chk("busy", 32'(busy), 32'(t_valid && (cyc == t_done || cyc == t_grant + 1)));
    chk("req_err", 32'(req_err), 32'(err_cyc >= 0 && cyc > err_cyc));
    if (e_dat_ok) chk("mem_dat", 32'(mem_dat), 32'(e_dat));
`ifdef SHMEM_PERF_CNT_EN
    chk("perf_ld", 32'(perf_ld), p_ld);
    chk("perf_st", 32'(perf_st), p_st);
    chk("perf_wait", 32'(perf_wait), p_wait);
`else
    chk("perf_ld", 32'(perf_ld), 0);
    chk("perf_st", 32'(perf_st), 0);
    chk("perf_wait", 32'(perf_wait), 0);
`endif
    acc_now = t_valid && cyc == t_grant + 1;
    if (t_valid && cyc == t_done) begin
      done_cyc[t_core] = cyc;
      if (t_st) p_st++; else p_ld++;
      t_valid = 0;
    end
    // cores drop after the edge that showed them val_data
    for (int k = 0; k < N; k++)
      if (done_cyc[k] == cyc - 1) begin
        c_act[k] = 0;
        if (c_renew[k]) new_req(k);
      end
    if (rand_en)
      for (int k = 0; k < N; k++)
        if (!c_act[k] && $urandom_range(99) < rand_pct) new_req(k);
    reset = rst_pending;
    for (int k = 0; k < N; k++) begin
      mem_req_ld[k] = c_act[k] && c_ld[k];
      mem_req_st[k] = c_act[k] && c_st[k];
      if (t_valid && t_core == k) begin
        addr_flat[k*AW +: AW]  = 12'($urandom);
        wdata_flat[k*DW +: DW] = 8'($urandom);
      end else begin
        addr_flat[k*AW +: AW]  = c_addr[k];
        wdata_flat[k*DW +: DW] = c_data[k];
      end
    end
    reqv = mem_req_ld | mem_req_st;
    if (|reqv && e_val == '0 && !acc_now) p_wait++;
    if (rst_pending) begin
      t_valid = 0; m_rr = 0; m_free = cyc + 1; m_gcyc = -1; err_cyc = -1;
      e_dat = '0; e_dat_ok = 1; p_ld = 0; p_st = 0; p_wait = 0;
      for (int k = 0; k < N; k++) begin c_act[k] = 0; done_cyc[k] = -10; end
    end else if (!t_valid && cyc >= m_free) begin
      pend = reqv;
      if (cyc == m_gcyc) pend[m_gcore] = 1'b0;
      g = -1;
      for (int i = 0; i < N; i++)
        if (g < 0 && pend[(m_rr + i) % N]) g = (m_rr + i) % N;
      if (g >= 0) begin
        t_valid = 1; t_core = g; t_grant = cyc; t_done = cyc + 2;
        t_st = c_st[g]; t_addr = c_addr[g]; t_data = c_data[g];
        if (c_ld[g] && c_st[g] && err_cyc < 0) err_cyc = cyc;
        m_rr = (g + 1) % N; m_free = cyc + 3; m_gcyc = cyc + 3; m_gcore = g;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((t_valid || any_act()) && n < 2000) begin cycle(); n++; end
    n_checks++;
    assert (n < 2000) else begin
      n_fail++;
      $error("FAIL wait_idle: observed %0d cycles expected < 2000", n);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int last7, n_other;
    reset = 1; mem_req_ld = '0; mem_req_st = '0; addr_flat = '0; wdata_flat = '0;
    for (int k = 0; k < N; k++) begin
      c_act[k] = 0; c_renew[k] = 0; done_cyc[k] = -10; c_addr[k] = '0; c_data[k] = '0;
    end
    for (int a = 0; a < 4096; a++) mk[a] = 0;

    // reset
    rst_pending = 1; cycles(2); rst_pending = 0;
    chk("rst_val_data", 32'(val_data), 0);
    chk("rst_mem_dat", 32'(mem_dat), 0);

    // store then load from core 3
    issue(3, 0, 1, 12'h123, 8'hA5); cycles(3);
    chk("t1_st_val", 32'(val_data), 32'h0008);
    wait_idle();
    issue(3, 1, 0, 12'h123, 8'h00); cycles(3);
    chk("t1_ld_val", 32'(val_data), 32'h0008);
    chk("t1_ld_dat", 32'(mem_dat), 32'hA5);
    wait_idle();

    // three simultaneous loads from rr_ptr = 0
    rst_pending = 1; cycle(); rst_pending = 0;
    issue(0, 1, 0, 12'h123, 0); issue(5, 1, 0, 12'h123, 0); issue(15, 1, 0, 12'h123, 0);
    cycles(3); chk("t2_g0", 32'(val_data), 32'h0001);
    cycles(3); chk("t2_g5", 32'(val_data), 32'h0020);
    cycles(3); chk("t2_g15", 32'(val_data), 32'h8000);
    wait_idle();
    issue(1, 1, 0, 12'h123, 0); issue(0, 1, 0, 12'h123, 0);
    cycles(3); chk("t2_rr_wrap", 32'(val_data), 32'h0001);
    wait_idle();

    // core 7 never lets go, random traffic from the others
    c_renew[7] = 1; issue(7, 1, 0, 12'h123, 0);
    rand_en = 1; rand_pct = 20; last7 = -100; n_other = 0;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (val_data[7]) begin
        if (last7 >= 0) chk("t3_gap_ge4", 32'(cyc - last7 >= 4), 1);
        last7 = cyc;
      end
      if (|(val_data & ~16'h0080)) n_other++;
    end
    chk("t3_others_served", 32'(n_other > 0), 1);
    c_renew[7] = 0; rand_en = 0;
    wait_idle();

    // ld and st together
    issue(2, 1, 1, 12'h0FF, 8'h3C); cycles(3);
    chk("t4_val", 32'(val_data), 32'h0004);
    wait_idle();
    chk("t4_req_err", 32'(req_err), 1);
    issue(2, 1, 0, 12'h0FF, 0); cycles(3);
    chk("t4_ld_dat", 32'(mem_dat), 32'h3C);
    wait_idle();

    // reset while a store is in ACCESS
    issue(4, 0, 1, 12'h010, 8'h11); wait_idle();
    issue(4, 0, 1, 12'h010, 8'h77); cycle();
    rst_pending = 1; cycle(); rst_pending = 0;
    cycle();
    chk("t5_val", 32'(val_data), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_err", 32'(req_err), 0);
    issue(4, 1, 0, 12'h010, 0); cycles(3);
    chk("t5_mem_kept", 32'(mem_dat), 32'h11);
    wait_idle();

    // long random phase
    rand_en = 1; rand_pct = 10;
    cycles(1500);
    rand_en = 0;
    wait_idle();

    // counters: 3 loads, 2 stores
    rst_pending = 1; cycle(); rst_pending = 0;
    for (int i = 0; i < 5; i++) begin
      issue(6 + i, i < 3, i >= 3, 12'h123 + 12'(i), 8'(i));
      wait_idle();
    end
    cycle();
`ifdef SHMEM_PERF_CNT_EN
    chk("t6_perf_ld", 32'(perf_ld), 3);
    chk("t6_perf_st", 32'(perf_st), 2);
`else
    chk("t6_perf_ld", 32'(perf_ld), 0);
    chk("t6_perf_st", 32'(perf_st), 0);
    chk("t6_perf_wait", 32'(perf_wait), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
